// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 matrix-multiplier stream sequencer.
//   - FSM state encoding
//   - operand/result widths and per-job element counts
//   - multiplier element index map (sel_in values, row-major A then B)
package mm_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = 17;
  localparam int unsigned N_ELEM = 8;
  localparam int unsigned N_RES  = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } seq_state_e;

  localparam logic [2:0] IDX_A00 = 3'd0;
  localparam logic [2:0] IDX_A01 = 3'd1;
  localparam logic [2:0] IDX_A10 = 3'd2;
  localparam logic [2:0] IDX_A11 = 3'd3;
  localparam logic [2:0] IDX_B00 = 3'd4;
  localparam logic [2:0] IDX_B01 = 3'd5;
  localparam logic [2:0] IDX_B10 = 3'd6;
  localparam logic [2:0] IDX_B11 = 3'd7;

endpackage

// File: rtl/mm_stream_sequencer.sv
// Stream sequencer for the 2x2 matrix multiplier.
// Takes eight operand bytes (A00..A11, B00..B11) on a valid/ready input,
// writes each into the multiplier, then streams the four products
// C00, C01, C10, C11 on a valid/ready output with a last flag.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset (shared with multiplier)
//   s_valid/s_data/s_ready            operand byte stream in
//   mm_sel_in/mm_input_val/mm_execute multiplier write port (execute low = write)
//   mm_sel_out/mm_out                 multiplier result select / result
//   m_valid/m_data/m_last/m_ready     result stream out
//   busy                              job in progress
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD   | accepting operand bytes, one multiplier write per accept
// ST_SETTLE | one cycle while the final write lands in the multiplier
// ST_DRAIN  | presenting C00..C11 from the multiplier, one per handshake
module mm_stream_sequencer
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [2:0]        mm_sel_in,
  output logic [DATA_W-1:0] mm_input_val,
  output logic              mm_execute,
  output logic [1:0]        mm_sel_out,
  input  logic [RES_W-1:0]  mm_out,
  output logic              m_valid,
  output logic [RES_W-1:0]  m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
);

  localparam logic [2:0] CNT_LAST = 3'(N_ELEM - 1);
  localparam logic [1:0] IDX_LAST = 2'(N_RES - 1);

  seq_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [2:0]        sel_in_q, sel_in_d;
  logic [DATA_W-1:0] input_val_q, input_val_d;
  logic              execute_q, execute_d;
  logic [1:0]        sel_out_q, sel_out_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      idx_q       <= '0;
      sel_in_q    <= '0;
      input_val_q <= '0;
      execute_q   <= 1'b1;
      sel_out_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sel_in_q    <= sel_in_d;
      input_val_q <= input_val_d;
      execute_q   <= execute_d;
      sel_out_q   <= sel_out_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sel_in_d    = sel_in_q;
    input_val_d = input_val_q;
    // The multiplier writes on every cycle with execute low, so it is
    // released by default and pulled low only for a cycle carrying a byte.
    execute_d   = 1'b1;
    sel_out_d   = sel_out_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_LOAD: begin
        if (s_valid) begin
          input_val_d = s_data;
          sel_in_d    = cnt_q;
          execute_d   = 1'b0;
          busy_d      = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_SETTLE: begin
        sel_out_d = '0;
        idx_d     = '0;
        state_d   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            sel_out_d = '0;
            busy_d    = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            idx_d     = idx_q + 2'd1;
            sel_out_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  assign s_ready      = (state_q == ST_LOAD);
  assign m_valid      = (state_q == ST_DRAIN);
  // m_data is taken straight from the multiplier; it stays stable under
  // backpressure because sel_out only moves on a handshake.
  assign m_data       = mm_out;
  assign m_last       = m_valid && (idx_q == IDX_LAST);
  assign mm_sel_in    = sel_in_q;
  assign mm_input_val = input_val_q;
  assign mm_execute   = execute_q;
  assign mm_sel_out   = sel_out_q;
  assign busy         = busy_q;

endmodule
